run_ctrl: RTL
=============

# run_ctrl

Run sequencer between the host handshake (`req`/`done`) and the single-cycle core (PC, Control, reg_file, alu, dat_mem). It holds the core in reset while idle, releases it for a run on host request, and stops it when Control raises `Halt`. It reports completion, counts executed cycles, and optionally aborts a runaway program with a watchdog.

## Interface
Parameters:
- `CW`, 16: width of the cycle counter.
- `RST_CYC`, 2: number of cycles the core reset is held after a start, at least 1.
- `TIMEOUT`, 4096: watchdog limit in RUN cycles; must be at most 2^CW−1.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  host run request, level-sensitive.
- `halt`  in  1  `Halt` from the Control decoder.
- `core_rst`  out  1  reset to PC and core state; active-high.
- `core_run`  out  1  core enable; PC advance, register write and memory write are gated by it.
- `busy`  out  1  high in RST or RUN.
- `done`  out  1  run finished; high only in DONE.
- `timeout`  out  1  the finished run was ended by the watchdog.
- `cycles`  out  CW  number of RUN cycles in the current or last run.

## Operation
- The FSM has four states: IDLE, RST, RUN and DONE.
- The FSM is Moore. Every output is a registered function of state, counters and flags.
- On `reset`:
  - state = IDLE, `core_rst`=1, `core_run`=0, `busy`=0, `done`=0, `timeout`=0, `cycles`=0.
- IDLE:
  - Outputs: `core_rst`=1, `core_run`=0.
  - `req`=1 → RST. On that edge, `cycles` and `timeout` clear and the reset counter loads RST_CYC−1.
- RST:
  - Outputs: `core_rst`=1, `busy`=1.
  - The reset counter decrements each cycle. When it reaches 0, go to RUN.
  - `req`=0 → IDLE (abort).
- RUN:
  - Outputs: `core_rst`=0, `core_run`=1, `busy`=1.
  - `cycles` increments every cycle and saturates at 2^CW−1; it never wraps.
  - `halt`=1 → DONE. The halting cycle is counted.
  - `req`=0 → IDLE (abort). `cycles` holds its value and `done` is never raised.
  - `halt`=1 and `req`=0 on the same cycle: abort wins and the next state is IDLE.
- DONE:
  - Outputs: `done`=1, `core_run`=0, `core_rst`=0. The core state is frozen for host readout of dat_mem.
  - `cycles` and `timeout` hold their values.
  - `req`=0 → IDLE.
  - Holding `req`=1 keeps the FSM in DONE. It does not restart the run.
- `halt` is ignored outside RUN. That includes X/garbage on `halt` while the core is held in reset.
- Assertion of `reset` in any state returns immediately to IDLE with reset values, including mid-run.

## Timing
- Start latency:
  - `req` is sampled high at edge t0.
  - `busy`=1 and `core_rst`=1 from t0.
  - `core_rst` falls and `core_run` rises at edge t0+RST_CYC.
- Run length: if `halt` is high during the k-th RUN cycle, then at the following edge `cycles`=k, `done`=1 and `core_run`=0.
- End of handshake: `req` is sampled low in DONE at edge t1. At t1, `done`=0 and `core_rst`=1.
- Restart: the earliest restart is `req` high at the edge after t1.
- No combinational path exists from any input to any output.

## Configuration
- Macro: `RUN_CTRL_WATCHDOG_EN`.
- Defined:
  - In RUN, when `cycles` would reach TIMEOUT without `halt`, the FSM enters DONE with `timeout`=1 and `cycles`=TIMEOUT.
  - If `halt` is high on the same cycle, the run counts as a normal halt and `timeout`=0.
- Undefined:
  - No watchdog. `timeout` is tied to 0.
  - A run without `halt` stays in RUN until `req` falls. `cycles` saturates.

## Test plan
- Reset defaults, RST_CYC=2. Assert `reset` mid-run, then release → all outputs at reset values; `core_rst`=1.
- Normal run. `req`=1 at t0, `halt` pulsed in RUN cycle 5 → `core_run`=1 at t0+2; `done`=1 and `cycles`=5 one edge after `halt`. Drop `req` → IDLE next edge.
- Abort. Drop `req` at RUN cycle 3 with `halt`=1 on that same cycle → IDLE, `done` never asserted, `cycles`=3.
- Held `req` after done. Keep `req`=1 for 10 cycles in DONE → state stays DONE and `cycles` is unchanged. A restart only occurs after `req` has been low for at least one cycle.
- With `RUN_CTRL_WATCHDOG_EN`, TIMEOUT=20, `halt` never asserted → DONE with `timeout`=1 and `cycles`=20. Without the macro, same stimulus → still in RUN at cycle 100 with `timeout`=0.
- Saturation. CW=4, no watchdog, run 20 cycles → `cycles` holds at 15.

Source files
------------

// File: rtl/run_ctrl.sv
// run_ctrl: run sequencer between the host handshake and a single-cycle core.
// It holds the core in reset while idle and releases it for one run on a host
// request. The run stops on Halt from Control, or on a host abort. The
// sequencer then reports completion and the number of RUN cycles executed.
//
// Build option:
//   RUN_CTRL_WATCHDOG_EN  when defined, a run that reaches TIMEOUT RUN cycles
//                         without Halt ends in DONE with timeout=1. When
//                         undefined, there is no watchdog and timeout stays 0.
//
// Parameters:
//   CW       width of the cycle counter
//   RST_CYC  cycles the core reset is held after a start (>= 1)
//   TIMEOUT  watchdog limit in RUN cycles (<= 2^CW-1)
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   req       host run request (level)
//   halt      Halt from the Control decoder, only looked at in RUN
//   core_rst  reset to PC and core state (active-high)
//   core_run  core enable for PC advance, register write and memory write
//   busy      high in RST or RUN
//   done      run finished, high only in DONE
//   timeout   the finished run was ended by the watchdog
//   cycles    RUN cycles in the current or last run (saturating)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | core held in reset, waiting for req
// RST   | core reset held for RST_CYC cycles after a start
// RUN   | core enabled, cycles counting, waiting for halt / abort
// DONE  | run finished, core frozen for readout until req falls

module run_ctrl #(
    parameter int CW      = 16,
    parameter int RST_CYC = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          halt,
    output logic          core_rst,
    output logic          core_run,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [CW-1:0] cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int            RW        = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RW-1:0] RCNT_LOAD = RW'(RST_CYC - 1);
    localparam logic [CW-1:0] CYC_MAX   = '1;

    if (RST_CYC < 1) begin : g_bad_rst_cyc
        $error("run_ctrl: RST_CYC must be at least 1");
    end
    if (TIMEOUT < 1 || TIMEOUT > (2 ** CW) - 1) begin : g_bad_timeout
        $error("run_ctrl: TIMEOUT must be in 1 .. 2^CW-1");
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
`endif

    state_t        state, state_nxt;
    logic [RW-1:0] rcnt, rcnt_nxt;
    logic [CW-1:0] cyc_q, cyc_nxt, cyc_inc;
    logic          to_q, to_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            rcnt  <= '0;
            cyc_q <= '0;
            to_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            rcnt  <= rcnt_nxt;
            cyc_q <= cyc_nxt;
            to_q  <= to_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rcnt_nxt  = rcnt;
        cyc_nxt   = cyc_q;
        to_nxt    = to_q;
        cyc_inc   = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + 1'b1;

        case (state)
            S_IDLE: begin
                if (req) begin
                    state_nxt = S_RST;
                    rcnt_nxt  = RCNT_LOAD;
                    cyc_nxt   = '0;
                    to_nxt    = 1'b0;
                end
            end
            S_RST: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (rcnt == '0) begin
                    state_nxt = S_RUN;
                end else begin
                    rcnt_nxt = rcnt - 1'b1;
                end
            end
            S_RUN: begin
                // The last RUN cycle is counted whether it ends by halt or by abort.
                cyc_nxt = cyc_inc;
                if (!req) begin
                    state_nxt = S_IDLE;
                end else if (halt) begin
                    state_nxt = S_DONE;
`ifdef RUN_CTRL_WATCHDOG_EN
                end else if (cyc_inc == TO_VAL) begin
                    state_nxt = S_DONE;
                    to_nxt    = 1'b1;
`endif
                end
            end
            S_DONE: begin
                if (!req) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and then registered, so each
    // output changes on the same edge as the state it reflects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rst <= 1'b1;
            core_run <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            core_rst <= (state_nxt == S_IDLE) || (state_nxt == S_RST);
            core_run <= (state_nxt == S_RUN);
            busy     <= (state_nxt == S_RST) || (state_nxt == S_RUN);
            done     <= (state_nxt == S_DONE);
        end
    end

    assign cycles  = cyc_q;
    assign timeout = to_q;

endmodule
